// File: rtl/generic_io_dft_pkg.sv
// Shared definitions for the IO-DFT pattern source and the input-side MISR:
// FSM states, maximal-length LFSR tap masks and the zero-seed substitute.
package generic_io_dft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } dft_state_e;

  // Loaded instead of an all-zero seed, which would lock the LFSR up.
  localparam logic [31:0] LFSR_ZERO_SUB = 32'h0000_0001;

  // Fibonacci tap masks (bit i set = stage i feeds the XOR), maximal length.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    logic [31:0] m;
    case (w)
      2:       m = 32'h0000_0003;
      3:       m = 32'h0000_0006;
      4:       m = 32'h0000_000C;
      5:       m = 32'h0000_0014;
      6:       m = 32'h0000_0030;
      7:       m = 32'h0000_0060;
      8:       m = 32'h0000_00B8;
      9:       m = 32'h0000_0110;
      10:      m = 32'h0000_0240;
      11:      m = 32'h0000_0500;
      12:      m = 32'h0000_0829;
      13:      m = 32'h0000_100D;
      14:      m = 32'h0000_2015;
      15:      m = 32'h0000_6000;
      16:      m = 32'h0000_D008;
      17:      m = 32'h0001_2000;
      18:      m = 32'h0002_0400;
      19:      m = 32'h0004_0023;
      20:      m = 32'h0009_0000;
      21:      m = 32'h0014_0000;
      22:      m = 32'h0030_0000;
      23:      m = 32'h0042_0000;
      24:      m = 32'h00E1_0000;
      25:      m = 32'h0120_0000;
      26:      m = 32'h0200_0023;
      27:      m = 32'h0400_0013;
      28:      m = 32'h0900_0000;
      29:      m = 32'h1400_0000;
      30:      m = 32'h2000_0029;
      31:      m = 32'h4800_0000;
      32:      m = 32'h8020_0003;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/crg_sync2.sv
// Two-flop synchronizer cell for single-bit asynchronous control inputs.
module crg_sync2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/generic_io_dft_lfsr.sv
// generic_lfsr: Fibonacci LFSR shifting toward the MSB, with seed load
// (load wins over advance) and a run-time tap mask.
module generic_lfsr
  import generic_io_dft_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic         adv_i,
  input  logic [W-1:0] seed_i,
  input  logic [W-1:0] taps_i,
  output logic [W-1:0] lfsr_o
);

  localparam logic [W-1:0] ZERO_SUB = LFSR_ZERO_SUB[W-1:0];

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;
  logic [W-1:0] seed_fix;
  logic         fb;

  assign seed_fix = (seed_i == '0) ? ZERO_SUB : seed_i;
  assign fb       = ^(lfsr_q & taps_i);

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_fix;
    end else if (adv_i) begin
      lfsr_d = {lfsr_q[W-2:0], fb};
    end
  end

  // Reset uses the substitute constant; IDLE reloads the real seed before
  // the pattern is ever selected onto the output.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lfsr_q <= ZERO_SUB;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/generic_io_dft_out.sv
// Output-side IO-DFT pattern source: drives an LFSR pattern into the output
// IO register under BootCFG (synchronized) or ATE (synchronous) control.
module generic_io_dft_out
  import generic_io_dft_pkg::*;
#(
  parameter int unsigned IO_DFT_OUT_DW = 8,
  parameter int unsigned LFSR_DW       = 8,
  parameter int unsigned PAT_CNT_W     = 16
) (
  input  logic                     func_clk,
  input  logic                     func_rst_n,
  input  logic [LFSR_DW-1:0]       bcfg_io_dft_out_lfsr_seed,
  input  logic                     bcfg_io_dft_out_ate_en,
  input  logic                     bcfg_io_dft_out_en,
  input  logic                     bcfg_io_dft_out_start,
  input  logic [PAT_CNT_W-1:0]     bcfg_io_dft_out_pat_num,
  output logic [PAT_CNT_W-1:0]     bcfg_io_dft_out_pat_cnt,
  output logic                     bcfg_io_dft_out_done,
  input  logic                     io_dft_out_en,
  input  logic                     io_dft_out_start,
  input  logic [IO_DFT_OUT_DW-1:0] func_datap_in,
  output logic [IO_DFT_OUT_DW-1:0] func_datap_io_reg_d,
  output logic                     io_dft_out_active
);

  localparam logic [31:0] TAPS_FULL = lfsr_taps(LFSR_DW);

  logic                     en_sync, start_sync, en_eff, start_eff;
  dft_state_e               state_q, state_d;
  logic [PAT_CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic                     done_q, done_d;
  logic                     lfsr_load, lfsr_adv, adv_last;
  logic [LFSR_DW-1:0]       lfsr_val;
  logic [IO_DFT_OUT_DW-1:0] dout_q, dout_d;
  logic                     active_q, active_d;

  crg_sync2 u_sync_en (
    .clk_i   (func_clk),
    .rst_n_i (func_rst_n),
    .d_i     (bcfg_io_dft_out_en),
    .q_o     (en_sync)
  );

  crg_sync2 u_sync_start (
    .clk_i   (func_clk),
    .rst_n_i (func_rst_n),
    .d_i     (bcfg_io_dft_out_start),
    .q_o     (start_sync)
  );

  assign en_eff    = bcfg_io_dft_out_ate_en ? io_dft_out_en    : en_sync;
  assign start_eff = bcfg_io_dft_out_ate_en ? io_dft_out_start : start_sync;

  assign cnt_inc  = cnt_q + 1'b1;
  assign adv_last = (bcfg_io_dft_out_pat_num != '0) && (cnt_inc == bcfg_io_dft_out_pat_num);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en_eff) state_d = ST_ARMED;
      end
      ST_ARMED, ST_RUN: begin
        if (start_eff) begin
          lfsr_adv = 1'b1;
          cnt_d    = (&cnt_q) ? cnt_q : cnt_inc;
          state_d  = adv_last ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    // Dropping enable overrides everything, including a same-edge start drop.
    if (!en_eff) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      lfsr_adv = 1'b0;
    end
  end

  assign lfsr_load = (state_q == ST_IDLE) || !en_eff;
  assign done_d    = (state_d == ST_DONE);
  assign active_d  = (state_q != ST_IDLE);
  assign dout_d    = active_d ? lfsr_val[IO_DFT_OUT_DW-1:0] : func_datap_in;

  generic_lfsr #(.W(LFSR_DW)) u_lfsr (
    .clk_i   (func_clk),
    .rst_n_i (func_rst_n),
    .load_i  (lfsr_load),
    .adv_i   (lfsr_adv),
    .seed_i  (bcfg_io_dft_out_lfsr_seed),
    .taps_i  (TAPS_FULL[LFSR_DW-1:0]),
    .lfsr_o  (lfsr_val)
  );

  always_ff @(posedge func_clk or negedge func_rst_n) begin
    if (!func_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      dout_q   <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
      active_q <= active_d;
    end
  end

  assign bcfg_io_dft_out_pat_cnt = cnt_q;
  assign bcfg_io_dft_out_done    = done_q;
  assign func_datap_io_reg_d     = dout_q;
  assign io_dft_out_active       = active_q;

endmodule
